// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, imem request, {pc,instr} FIFO to decode (option: IFU_BOUNDS_CHECK_EN)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     fifo_pc    [DEPTH];
    logic [31:0]     fifo_instr [DEPTH];

    logic            pop;
    logic            push_ok;
    logic            push;
    logic            range_fault;

    // The memory is combinational, so the PC itself is the request address.
    assign instr_addr = pc;
    assign out_valid  = (count != '0);
    assign out_pc     = fifo_pc[rd_ptr];
    assign out_instr  = fifo_instr[rd_ptr];

    assign pop     = out_valid & out_ready;
    // A simultaneous pop frees a slot this cycle, so a full FIFO can still accept.
    assign push_ok = (state == ST_FETCH) & fetch_en & ~redirect_valid
                   & ((count < CW'(DEPTH)) | pop);

`ifdef IFU_BOUNDS_CHECK_EN
    logic in_range;

    // Word index beyond the memory turns the would-be push into a fault.
    assign in_range    = ({2'b00, pc[31:2]} < 32'(MEM_WORDS));
    assign push        = push_ok & in_range;
    assign range_fault = push_ok & ~in_range;
`else
    logic [31:0] unused_mem_words;

    // Without the range check out-of-range addresses simply alias in memory.
    assign unused_mem_words = 32'(MEM_WORDS);
    assign push             = push_ok;
    assign range_fault      = 1'b0;
`endif

    // PC, FIFO pointers/storage and the FETCH/FAULT state machine with its registered fault outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fault    <= 1'b0;
            fault_pc <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= 32'h0;
                fifo_instr[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            // Redirect flushes everything, including a head decode may be looking at.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= redirect_pc;
            if (redirect_pc[1:0] == 2'b00) begin
                state <= ST_FETCH;
                fault <= 1'b0;
            end else begin
                state    <= ST_FAULT;
                fault    <= 1'b1;
                fault_pc <= redirect_pc;
            end
        end else begin
            if (range_fault) begin
                state    <= ST_FAULT;
                fault    <= 1'b1;
                fault_pc <= pc;
            end
            if (push) begin
                fifo_pc[wr_ptr]    <= pc;
                fifo_instr[wr_ptr] <= instr_data;
                wr_ptr             <= wr_ptr + AW'(1);
                pc                 <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 2;
    localparam int          MEM_WORDS = 512;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        fetch_en       = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        out_ready      = 1'b0;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO contents as {pc, instr}, occupancy, PC and fault status.
    logic [63:0] exp_q [$];
    int          m_cnt;
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fault_pc;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .instr_addr    (instr_addr),
        .instr_data    (instr_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault),
        .fault_pc      (fault_pc)
    );

    always #5 clk = ~clk;

    // Memory image: word i holds i + 0x100, aliasing over the whole address space.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'h100;
    endfunction

    assign instr_data = mem_word(instr_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt      = 0;
        m_pc       = RESET_PC;
        m_fault    = 1'b0;
        m_fault_pc = 32'h0;
    endtask

    // One clock edge of the fetch rules, applied to the inputs currently driven.
    task automatic step_model();
        bit pop;
        bit want;
        pop = (m_cnt != 0) && out_ready;
        if (redirect_valid) begin
            exp_q.delete();
            m_cnt = 0;
            m_pc  = redirect_pc;
            if (redirect_pc[1:0] == 2'b00) begin
                m_fault = 1'b0;
            end else begin
                m_fault    = 1'b1;
                m_fault_pc = redirect_pc;
            end
            return;
        end
        want = !m_fault && fetch_en && ((m_cnt < DEPTH) || pop);
`ifdef IFU_BOUNDS_CHECK_EN
        if (want && ((m_pc / 4) >= MEM_WORDS)) begin
            want       = 1'b0;
            m_fault    = 1'b1;
            m_fault_pc = m_pc;
        end
`endif
        if (pop) m_cnt--;
        if (want) begin
            exp_q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
            m_cnt++;
        end
    endtask

    // Advance one edge (model follows the DUT), then drive the next cycle's inputs.
    task automatic tick(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        if (rst_n) step_model();
        #1;
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Monitor: status every cycle, and each accepted head against the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            chk("instr_addr", instr_addr, m_pc);
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            chk("fault", {31'b0, fault}, {31'b0, m_fault});
            chk("fault_pc", fault_pc, m_fault_pc);
            if (rst_n && out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e[63:32]);
                    chk("out_instr", out_instr, e[31:0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        int          r;
        model_reset();

        // Reset state, seen while rst_n is still low.
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_instr_addr", instr_addr, RESET_PC);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);

        // Decode stalled from the start: FIFO fills with pc 0,4 and the PC holds at 8.
        rst_n = 1'b1;
        repeat (4) tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_instr_addr", instr_addr, 32'h8);
        chk("full_out_pc", out_pc, 32'h0);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Fill again, then redirect a full FIFO to 0x40.
        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b1, 32'h40);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_out_valid", {31'b0, out_valid}, 32'h0);
        chk("redir_instr_addr", instr_addr, 32'h40);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_out_pc", out_pc, 32'h40);

        // Misaligned redirect faults; an aligned one recovers.
        tick(1'b1, 1'b1, 1'b1, 32'h42);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_fault", {31'b0, fault}, 32'h1);
        chk("mis_fault_pc", fault_pc, 32'h42);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_out_valid", {31'b0, out_valid}, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h10);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("recover_fault", {31'b0, fault}, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("recover_out_pc", out_pc, 32'h10);

        // Last word of a 512-word memory, then the word beyond it.
        tick(1'b1, 1'b1, 1'b1, 32'h7FC);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("edge_out_pc", out_pc, 32'h7FC);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef IFU_BOUNDS_CHECK_EN
        chk("oob_fault", {31'b0, fault}, 32'h1);
        chk("oob_fault_pc", fault_pc, 32'h800);
`else
        chk("oob_fault", {31'b0, fault}, 32'h0);
        chk("oob_out_pc", out_pc, 32'h800);
`endif
        tick(1'b1, 1'b1, 1'b1, 32'h100);
        repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Asynchronous reset between clock edges, mid-stream.
        @(posedge clk);
        step_model();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_out_valid", {31'b0, out_valid}, 32'h0);
        chk("async_instr_addr", instr_addr, RESET_PC);
        chk("async_fault", {31'b0, fault}, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;

        // One-cycle latency after reset release, then one word per cycle.
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("first_out_valid", {31'b0, out_valid}, 32'h1);
        chk("first_out_pc", out_pc, RESET_PC);
        chk("first_out_instr", out_instr, mem_word(RESET_PC));
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("second_out_pc", out_pc, RESET_PC + 32'h4);

        // Randomized traffic, including misaligned and wrapping redirects.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 31);
            if (r == 0)      rpc = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (r == 1) rpc = 32'hFFFF_FFF8;
            else if (r == 2) rpc = 32'h0000_07F8;
            else             rpc = {20'b0, 10'($urandom_range(0, 1023)), 2'b00};
            tick($urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) == 0,
                 rpc);
        end

        // Drain: everything pushed must have been delivered.
        tick(1'b1, 1'b1, 1'b1, 32'h0);
        repeat (6) tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
